instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the program counter and instruction register,
// issues single-word reads to instruction memory and aborts a read that goes
// unanswered for TIMEOUT cycles.
module instr_fetch #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PC_clr,
  input  logic          PC_inc,
  input  logic          PC_ld,
  input  logic          I_rd,
  input  logic          IR_ld,
  input  logic [15:0]   imem_rdata,
  input  logic          imem_ack,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  output logic [15:0]   instr,
  output logic [AW-1:0] pc,
  output logic          fetch_busy,
  output logic          fetch_done,
  output logic          fetch_err
);

  // Wide enough to hold the value TIMEOUT itself.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          inc_latched, inc_latched_next;
  logic [AW-1:0] pc_next;
  logic [15:0]   instr_next;
  logic          done_next;
  logic          err_next;
  logic [AW-1:0] branch_offset;

  // The request, the busy flag and the address all follow directly from the
  // registered state and pc, so they are stable for the whole REQ period.
  assign imem_req   = (state == REQ);
  assign fetch_busy = (state == REQ);
  assign imem_addr  = pc;

  // Branch displacement is the signed low byte of the current instruction.
  assign branch_offset = AW'(signed'(instr[7:0]));

  // Next-state and datapath updates; clear beats branch load beats fetch
  // start, and a REQ in progress only listens to ack, timeout and clear.
  always_comb begin
    state_next       = state;
    wait_cnt_next    = wait_cnt;
    inc_latched_next = inc_latched;
    pc_next          = pc;
    instr_next       = instr;
    done_next        = 1'b0;
    err_next         = fetch_err;

    if (PC_clr) begin
      state_next    = IDLE;
      wait_cnt_next = '0;
      pc_next       = '0;
      err_next      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PC_ld) begin
            pc_next = pc + branch_offset - AW'(1);
          end else if (I_rd && IR_ld) begin
            state_next       = REQ;
            wait_cnt_next    = '0;
            inc_latched_next = PC_inc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            instr_next    = imem_rdata;
            done_next     = 1'b1;
            state_next    = IDLE;
            wait_cnt_next = '0;
            if (inc_latched) begin
              pc_next = pc + AW'(1);
            end
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state_next    = IDLE;
            wait_cnt_next = '0;
            err_next      = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt + CW'(1);
          end
        end
        default: begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset; reset also drops
  // any ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      inc_latched <= 1'b0;
      pc          <= '0;
      instr       <= 16'h0000;
      fetch_done  <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      inc_latched <= inc_latched_next;
      pc          <= pc_next;
      instr       <= instr_next;
      fetch_done  <= done_next;
      fetch_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a scoreboard of expected fetch
// results popped whenever the fetch unit signals completion.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_clr, PC_inc, PC_ld, I_rd, IR_ld;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        fetch_busy, fetch_done, fetch_err;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  exp_pc;
  int          checks   = 0;
  int          failures = 0;

  instr_fetch #(.AW(8), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .PC_clr     (PC_clr),
    .PC_inc     (PC_inc),
    .PC_ld      (PC_ld),
    .I_rd       (I_rd),
    .IR_ld      (IR_ld),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .instr      (instr),
    .pc         (pc),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case something leaves the bench waiting forever.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic clr, input logic inc, input logic ld,
                               input logic rd, input logic irld, input logic ack,
                               input logic [15:0] rdata);
    PC_clr     = clr;
    PC_inc     = inc;
    PC_ld      = ld;
    I_rd       = rd;
    IR_ld      = irld;
    imem_ack   = ack;
    imem_rdata = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Full fetch: request, hold for 'delay' REQ cycles while wiggling PC_inc and
  // PC_ld (both must be ignored), then ack with rdata.
  task automatic fetchAck(input logic [15:0] rdata, input logic inc, input int delay);
    exp_t e;
    int   n;
    logic [7:0] addr_at_issue;
    addr_at_issue = exp_pc;
    if (inc) exp_pc = exp_pc + 8'd1;
    e.instr = rdata;
    e.pc    = exp_pc;
    exp_q.push_back(e);
    applyStimulus(1'b0, inc, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b0, ~inc, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("req_high", imem_req, 1'b1);
    checkOutput("busy_high", fetch_busy, 1'b1);
    checkOutput("addr_issue", imem_addr, addr_at_issue);
    for (int i = 1; i < delay; i++) begin
      tick();
      checkOutput("addr_hold", {imem_req, imem_addr}, {1'b1, addr_at_issue});
    end
    applyStimulus(1'b0, ~inc, 1'b1, 1'b0, 1'b0, 1'b1, rdata);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n = 0;
    while (fetch_done !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    checkOutput("done_seen", fetch_done, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("sb_instr", instr, e.instr);
      checkOutput("sb_pc", pc, e.pc);
    end else begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end
    checkOutput("busy_after_ack", fetch_busy, 1'b0);
    tick();
    checkOutput("done_single", fetch_done, 1'b0);
  endtask

  // Fetch with no ack; counts REQ cycles until the abort.
  task automatic timeoutFetch(input logic inc);
    int n;
    applyStimulus(1'b0, inc, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    n = 0;
    while (imem_req === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("timeout_cycles", n, 8);
    checkOutput("timeout_err", fetch_err, 1'b1);
    checkOutput("timeout_no_done", fetch_done, 1'b0);
    checkOutput("timeout_busy", fetch_busy, 1'b0);
  endtask

  // Single-cycle branch load.
  task automatic branchLoad();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_instr", instr, 16'h0000);
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_busy", fetch_busy, 1'b0);
    checkOutput("rst_done", fetch_done, 1'b0);
    checkOutput("rst_err", fetch_err, 1'b0);
    exp_pc = 8'h00;

    // Basic fetch from address 0, ack after two cycles.
    fetchAck(16'h3105, 1'b1, 2);
    checkOutput("first_instr", instr, 16'h3105);
    checkOutput("first_pc", pc, 8'h01);

    // Walk pc up to 10; the last word fetched is 16'h5203.
    for (int i = 0; i < 9; i++) begin
      fetchAck((i == 8) ? 16'h5203 : 16'(16'h1000 + i), 1'b1, 1 + (i % 3));
    end
    checkOutput("pc_ten", pc, 8'd10);

    // Branch +3-1 from 10.
    branchLoad();
    checkOutput("branch_pos", pc, 8'd12);
    // Back to 10 via offset -1, then branch -2-1 from 10.
    exp_pc = 8'd12;
    fetchAck(16'h00FF, 1'b0, 1);
    branchLoad();
    checkOutput("branch_m1", pc, 8'd10);
    exp_pc = 8'd10;
    fetchAck(16'h12FE, 1'b0, 1);
    branchLoad();
    checkOutput("branch_neg", pc, 8'd7);
    exp_pc = 8'd7;

    // No ack: abort after 8 cycles, pc and instr untouched.
    timeoutFetch(1'b1);
    checkOutput("timeout_pc", pc, 8'd7);
    checkOutput("timeout_instr", instr, 16'h12FE);

    // Clear wipes error and pc.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("clr_err", fetch_err, 1'b0);
    checkOutput("clr_pc", pc, 8'd0);
    exp_pc = 8'd0;

    // Ack on the very cycle the timeout would fire counts as success.
    fetchAck(16'hABCD, 1'b1, 8);
    checkOutput("late_ack_err", fetch_err, 1'b0);

    // Reach pc=255 with zero offset branches, then wrap on increment.
    fetchAck(16'h0000, 1'b0, 1);
    branchLoad();
    branchLoad();
    checkOutput("pc_255", pc, 8'd255);
    exp_pc = 8'd255;
    fetchAck(16'h4444, 1'b1, 1);
    checkOutput("pc_wrap", pc, 8'd0);

    // Clear during REQ with a simultaneous ack.
    fetchAck(16'h7777, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hDEAD);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("clrreq_pc", pc, 8'd0);
    checkOutput("clrreq_instr", instr, 16'h7777);
    checkOutput("clrreq_req", imem_req, 1'b0);
    checkOutput("clrreq_done", fetch_done, 1'b0);
    exp_pc = 8'd0;

    // Reset mid-REQ with pc, instr and err all non-zero beforehand.
    fetchAck(16'h1234, 1'b1, 1);
    timeoutFetch(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    checkOutput("pre_rst_req", imem_req, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("midrst_pc", pc, 8'd0);
    checkOutput("midrst_instr", instr, 16'h0000);
    checkOutput("midrst_req", imem_req, 1'b0);
    checkOutput("midrst_busy", fetch_busy, 1'b0);
    checkOutput("midrst_done", fetch_done, 1'b0);
    checkOutput("midrst_err", fetch_err, 1'b0);

    // Stray ack while idle changes nothing.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("stray_instr", instr, 16'h0000);
    checkOutput("stray_pc", pc, 8'd0);
    checkOutput("stray_done", fetch_done, 1'b0);
    checkOutput("stray_busy", fetch_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
